// File: rtl/punc_lsu.sv
// Load/store unit for PUnC-family cores: sequences LD/ST/LDI/STI over a
// req/gnt/rvalid memory port and returns loaded data with n/z/p codes.
module punc_lsu #(
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned ADDR_W  = 16,
    parameter int unsigned OFF_W   = 9,
    parameter int unsigned TIMEOUT = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_cmd_valid,
    output logic              o_cmd_ready,
    input  logic [1:0]        i_cmd_op,
    input  logic [ADDR_W-1:0] i_cmd_base,
    input  logic [OFF_W-1:0]  i_cmd_off,
    input  logic [DATA_W-1:0] i_cmd_wdata,
    output logic              o_mem_req,
    output logic              o_mem_we,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [DATA_W-1:0] o_mem_wdata,
    input  logic              i_mem_gnt,
    input  logic              i_mem_rvalid,
    input  logic [DATA_W-1:0] i_mem_rdata,
    output logic              o_rsp_valid,
    output logic [DATA_W-1:0] o_rsp_data,
    output logic              o_rsp_n,
    output logic              o_rsp_z,
    output logic              o_rsp_p,
    output logic              o_rsp_err
);

    localparam int unsigned CNT_W    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam int unsigned TMO_LAST = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PTR_REQ,
        S_PTR_WAIT,
        S_ACC_REQ,
        S_ACC_WAIT,
        S_RESP
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [1:0]        r_op;
    logic [1:0]        w_op;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_cnt;

    logic              r_cmd_ready;
    logic              r_mem_req;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;
    logic              r_rsp_valid;
    logic [DATA_W-1:0] r_rsp_data;
    logic              r_rsp_n;
    logic              r_rsp_z;
    logic              r_rsp_p;
    logic              r_rsp_err;

    logic              w_cmd_ready;
    logic              w_mem_req;
    logic              w_mem_we;
    logic [ADDR_W-1:0] w_mem_addr;
    logic [DATA_W-1:0] w_mem_wdata;
    logic              w_rsp_valid;
    logic [DATA_W-1:0] w_rsp_data;
    logic              w_rsp_n;
    logic              w_rsp_z;
    logic              w_rsp_p;
    logic              w_rsp_err;

    logic [ADDR_W-1:0] w_off_sext;
    logic [ADDR_W-1:0] w_ea;
    logic              w_tmo;
    logic              w_rd_neg;
    logic              w_rd_zero;

    // Effective address wraps modulo 2^ADDR_W.
    assign w_off_sext = ADDR_W'($signed(i_cmd_off));
    assign w_ea       = i_cmd_base + w_off_sext;
    assign w_tmo      = (TIMEOUT > 0) && (r_cnt == CNT_W'(TMO_LAST));
    assign w_rd_neg   = i_mem_rdata[DATA_W-1];
    assign w_rd_zero  = (i_mem_rdata == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next state plus the next value of every registered output.
    always_comb begin
        w_next      = r_state;
        w_op        = r_op;
        w_cnt       = r_cnt;
        w_cmd_ready = 1'b0;
        w_mem_req   = 1'b0;
        w_mem_we    = 1'b0;
        w_mem_addr  = r_mem_addr;
        w_mem_wdata = r_mem_wdata;
        w_rsp_valid = 1'b0;
        w_rsp_data  = r_rsp_data;
        w_rsp_n     = r_rsp_n;
        w_rsp_z     = r_rsp_z;
        w_rsp_p     = r_rsp_p;
        w_rsp_err   = r_rsp_err;

        case (r_state)
            S_IDLE: begin
                w_cmd_ready = 1'b1;
                if (i_cmd_valid) begin
                    w_cmd_ready = 1'b0;
                    w_op        = i_cmd_op;
                    w_cnt       = '0;
                    w_mem_req   = 1'b1;
                    w_mem_addr  = w_ea;
                    w_mem_wdata = i_cmd_op[0] ? i_cmd_wdata : '0;
                    if (i_cmd_op[1]) begin
                        w_next   = S_PTR_REQ;
                        w_mem_we = 1'b0;
                    end else begin
                        w_next   = S_ACC_REQ;
                        w_mem_we = i_cmd_op[0];
                    end
                end
            end
            S_PTR_REQ: begin
                w_mem_req = 1'b1;
                if (i_mem_gnt) begin
                    w_mem_req = 1'b0;
                    w_cnt     = '0;
                    w_next    = S_PTR_WAIT;
                end
            end
            S_PTR_WAIT: begin
                if (i_mem_rvalid) begin
                    w_next     = S_ACC_REQ;
                    w_mem_req  = 1'b1;
                    w_mem_we   = r_op[0];
                    w_mem_addr = i_mem_rdata[ADDR_W-1:0];
                end else if (w_tmo) begin
                    w_next      = S_RESP;
                    w_rsp_valid = 1'b1;
                    w_rsp_err   = 1'b1;
                    w_rsp_data  = '0;
                    w_rsp_n     = 1'b0;
                    w_rsp_z     = 1'b0;
                    w_rsp_p     = 1'b0;
                end else if (TIMEOUT > 0) begin
                    w_cnt = r_cnt + CNT_W'(1);
                end
            end
            S_ACC_REQ: begin
                w_mem_req = 1'b1;
                w_mem_we  = r_op[0];
                if (i_mem_gnt) begin
                    w_mem_req = 1'b0;
                    w_mem_we  = 1'b0;
                    w_cnt     = '0;
                    if (r_op[0]) begin
                        w_next      = S_RESP;
                        w_rsp_valid = 1'b1;
                        w_rsp_err   = 1'b0;
                        w_rsp_data  = '0;
                        w_rsp_n     = 1'b0;
                        w_rsp_z     = 1'b0;
                        w_rsp_p     = 1'b0;
                    end else begin
                        w_next = S_ACC_WAIT;
                    end
                end
            end
            S_ACC_WAIT: begin
                if (i_mem_rvalid) begin
                    w_next      = S_RESP;
                    w_rsp_valid = 1'b1;
                    w_rsp_err   = 1'b0;
                    w_rsp_data  = i_mem_rdata;
                    w_rsp_n     = w_rd_neg;
                    w_rsp_z     = w_rd_zero;
                    w_rsp_p     = !w_rd_neg && !w_rd_zero;
                end else if (w_tmo) begin
                    w_next      = S_RESP;
                    w_rsp_valid = 1'b1;
                    w_rsp_err   = 1'b1;
                    w_rsp_data  = '0;
                    w_rsp_n     = 1'b0;
                    w_rsp_z     = 1'b0;
                    w_rsp_p     = 1'b0;
                end else if (TIMEOUT > 0) begin
                    w_cnt = r_cnt + CNT_W'(1);
                end
            end
            S_RESP: begin
                w_next      = S_IDLE;
                w_cmd_ready = 1'b1;
            end
            default: begin
                w_next      = S_IDLE;
                w_cmd_ready = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_op        <= 2'b00;
            r_cnt       <= '0;
            r_cmd_ready <= 1'b1;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
            r_rsp_n     <= 1'b0;
            r_rsp_z     <= 1'b0;
            r_rsp_p     <= 1'b0;
            r_rsp_err   <= 1'b0;
        end else begin
            r_op        <= w_op;
            r_cnt       <= w_cnt;
            r_cmd_ready <= w_cmd_ready;
            r_mem_req   <= w_mem_req;
            r_mem_we    <= w_mem_we;
            r_mem_addr  <= w_mem_addr;
            r_mem_wdata <= w_mem_wdata;
            r_rsp_valid <= w_rsp_valid;
            r_rsp_data  <= w_rsp_data;
            r_rsp_n     <= w_rsp_n;
            r_rsp_z     <= w_rsp_z;
            r_rsp_p     <= w_rsp_p;
            r_rsp_err   <= w_rsp_err;
        end
    end

    assign o_cmd_ready = r_cmd_ready;
    assign o_mem_req   = r_mem_req;
    assign o_mem_we    = r_mem_we;
    assign o_mem_addr  = r_mem_addr;
    assign o_mem_wdata = r_mem_wdata;
    assign o_rsp_valid = r_rsp_valid;
    assign o_rsp_data  = r_rsp_data;
    assign o_rsp_n     = r_rsp_n;
    assign o_rsp_z     = r_rsp_z;
    assign o_rsp_p     = r_rsp_p;
    assign o_rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_punc_lsu.sv
// Directed bench for punc_lsu: memory responder with programmable grant delay,
// one task per scenario, hand-computed expectations.
module tb_punc_lsu;

    localparam logic [1:0] OP_LD  = 2'b00;
    localparam logic [1:0] OP_ST  = 2'b01;
    localparam logic [1:0] OP_LDI = 2'b10;
    localparam logic [1:0] OP_STI = 2'b11;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_cmd_valid = 1'b0;
    logic [1:0]  i_cmd_op = 2'b00;
    logic [15:0] i_cmd_base = 16'h0;
    logic [8:0]  i_cmd_off = 9'h0;
    logic [15:0] i_cmd_wdata = 16'h0;
    logic        o_cmd_ready, o_mem_req, o_mem_we;
    logic [15:0] o_mem_addr, o_mem_wdata;
    logic        i_mem_gnt = 1'b0;
    logic        i_mem_rvalid = 1'b0;
    logic [15:0] i_mem_rdata = 16'h0;
    logic        o_rsp_valid, o_rsp_n, o_rsp_z, o_rsp_p, o_rsp_err;
    logic [15:0] o_rsp_data;

    always #5 clk = ~clk;

    punc_lsu #(.DATA_W(16), .ADDR_W(16), .OFF_W(9), .TIMEOUT(8)) dut (
        .clk(clk), .rst(rst),
        .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready), .i_cmd_op(i_cmd_op),
        .i_cmd_base(i_cmd_base), .i_cmd_off(i_cmd_off), .i_cmd_wdata(i_cmd_wdata),
        .o_mem_req(o_mem_req), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr),
        .o_mem_wdata(o_mem_wdata), .i_mem_gnt(i_mem_gnt), .i_mem_rvalid(i_mem_rvalid),
        .i_mem_rdata(i_mem_rdata), .o_rsp_valid(o_rsp_valid), .o_rsp_data(o_rsp_data),
        .o_rsp_n(o_rsp_n), .o_rsp_z(o_rsp_z), .o_rsp_p(o_rsp_p), .o_rsp_err(o_rsp_err)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Responder controls (written by the test only) and access log (responder only).
    int          gnt_delay  = 0;
    bit          rvalid_en  = 1'b1;
    int          inject_req = 0;
    logic [15:0] mem [logic [15:0]];
    logic [15:0] log_addr [$];
    logic        log_we [$];
    logic [15:0] log_wdata [$];

    int          wait_cnt = 0;
    int          inject_seen = 0;
    logic [15:0] g_addr = 16'h0;
    logic [15:0] g_wdata = 16'h0;
    logic        g_we = 1'b0;

    // Memory model: grant after gnt_delay req cycles, rvalid on the following cycle.
    always @(negedge clk) begin
        i_mem_rvalid = 1'b0;
        if (rst) begin
            i_mem_gnt = 1'b0;
            wait_cnt  = 0;
        end else if (i_mem_gnt) begin
            i_mem_gnt = 1'b0;
            log_addr.push_back(g_addr);
            log_we.push_back(g_we);
            log_wdata.push_back(g_wdata);
            if (!g_we && rvalid_en) begin
                i_mem_rvalid = 1'b1;
                i_mem_rdata  = mem.exists(g_addr) ? mem[g_addr] : 16'h0;
            end
        end else if (o_mem_req) begin
            if (wait_cnt >= gnt_delay) begin
                i_mem_gnt = 1'b1;
                g_addr    = o_mem_addr;
                g_we      = o_mem_we;
                g_wdata   = o_mem_wdata;
                wait_cnt  = 0;
            end else begin
                wait_cnt++;
            end
        end
        if (inject_req != inject_seen) begin
            inject_seen  = inject_req;
            i_mem_rvalid = 1'b1;
            i_mem_rdata  = 16'hBEEF;
        end
    end

    int          c_lat;
    logic [15:0] c_data;
    logic [3:0]  c_nzpe;
    logic        c_ready;

    task automatic issue(input logic [1:0] op, input logic [15:0] base,
                         input logic [8:0] off, input logic [15:0] wd);
        @(negedge clk);
        i_cmd_valid = 1'b1;
        i_cmd_op    = op;
        i_cmd_base  = base;
        i_cmd_off   = off;
        i_cmd_wdata = wd;
        @(negedge clk);
        i_cmd_valid = 1'b0;
    endtask

    // Latency is counted in cycles after acceptance; -1 means no response seen.
    task automatic wait_rsp(input int start);
        bit got = 1'b0;
        c_lat = start;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            c_lat++;
            if (o_rsp_valid === 1'b1) begin
                got     = 1'b1;
                c_data  = o_rsp_data;
                c_nzpe  = {o_rsp_n, o_rsp_z, o_rsp_p, o_rsp_err};
                c_ready = o_cmd_ready;
            end
        end
        if (!got) c_lat = -1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({o_cmd_ready, o_mem_req, o_mem_we} !== 3'b100)
            $display("FAIL reset_ctrl: got ready/req/we=%b exp 100", {o_cmd_ready, o_mem_req, o_mem_we});
        else n_pass++;
        n_checks++;
        if ({o_mem_addr, o_mem_wdata, o_rsp_data} !== 48'h0)
            $display("FAIL reset_data: got addr=%h wdata=%h rsp=%h exp 0", o_mem_addr, o_mem_wdata, o_rsp_data);
        else n_pass++;
        n_checks++;
        if ({o_rsp_valid, o_rsp_n, o_rsp_z, o_rsp_p, o_rsp_err} !== 5'b0)
            $display("FAIL reset_rsp: got %b exp 00000", {o_rsp_valid, o_rsp_n, o_rsp_z, o_rsp_p, o_rsp_err});
        else n_pass++;
        rst = 1'b0;
    endtask

    task automatic test_ld_neg();
        int b = log_addr.size();
        mem[16'h2FFF] = 16'h8001;
        issue(OP_LD, 16'h3000, 9'h1FF, 16'h0);
        n_checks++;
        if ({o_mem_req, o_mem_we, o_mem_addr} !== {1'b1, 1'b0, 16'h2FFF})
            $display("FAIL ld_req: got req=%b we=%b addr=%h exp 1 0 2fff", o_mem_req, o_mem_we, o_mem_addr);
        else n_pass++;
        wait_rsp(1);
        n_checks++;
        if (c_lat !== 3) $display("FAIL ld_latency: got %0d exp 3", c_lat);
        else n_pass++;
        n_checks++;
        if ({c_data, c_nzpe, c_ready} !== {16'h8001, 4'b1000, 1'b0})
            $display("FAIL ld_rsp: got data=%h nzpe=%b ready=%b exp 8001 1000 0", c_data, c_nzpe, c_ready);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if ({o_rsp_valid, o_cmd_ready} !== 2'b01)
            $display("FAIL ld_pulse: got valid/ready=%b exp 01", {o_rsp_valid, o_cmd_ready});
        else n_pass++;
        n_checks++;
        if (log_addr.size() - b !== 1 || log_addr[b] !== 16'h2FFF)
            $display("FAIL ld_access: got count=%0d addr=%h exp 1 2fff", log_addr.size() - b, log_addr[b]);
        else n_pass++;
    endtask

    task automatic test_ldi_zero();
        int b = log_addr.size();
        mem[16'h0015] = 16'h0200;
        mem[16'h0200] = 16'h0000;
        issue(OP_LDI, 16'h0010, 9'd5, 16'h0);
        n_checks++;
        if ({o_mem_req, o_mem_we, o_mem_addr} !== {1'b1, 1'b0, 16'h0015})
            $display("FAIL ldi_ptr_req: got req=%b we=%b addr=%h exp 1 0 0015", o_mem_req, o_mem_we, o_mem_addr);
        else n_pass++;
        wait_rsp(1);
        n_checks++;
        if (c_lat !== 5) $display("FAIL ldi_latency: got %0d exp 5", c_lat);
        else n_pass++;
        n_checks++;
        if ({c_data, c_nzpe} !== {16'h0000, 4'b0100})
            $display("FAIL ldi_rsp: got data=%h nzpe=%b exp 0000 0100", c_data, c_nzpe);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (log_addr.size() - b !== 2 || log_addr[b] !== 16'h0015 || log_addr[b+1] !== 16'h0200
            || log_we[b] !== 1'b0 || log_we[b+1] !== 1'b0)
            $display("FAIL ldi_access: got count=%0d addr0=%h addr1=%h exp 2 0015 0200",
                     log_addr.size() - b, log_addr[b], log_addr[b+1]);
        else n_pass++;
    endtask

    task automatic test_sti();
        int b = log_addr.size();
        mem[16'h0040] = 16'h0100;
        issue(OP_STI, 16'h0040, 9'd0, 16'h1234);
        wait_rsp(1);
        n_checks++;
        if (c_lat !== 4) $display("FAIL sti_latency: got %0d exp 4", c_lat);
        else n_pass++;
        n_checks++;
        if ({c_data, c_nzpe} !== {16'h0000, 4'b0000})
            $display("FAIL sti_rsp: got data=%h nzpe=%b exp 0000 0000", c_data, c_nzpe);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (log_addr.size() - b !== 2 || log_addr[b] !== 16'h0040 || log_we[b] !== 1'b0)
            $display("FAIL sti_ptr_read: got count=%0d addr=%h we=%b exp 2 0040 0",
                     log_addr.size() - b, log_addr[b], log_we[b]);
        else n_pass++;
        n_checks++;
        if ({log_addr[b+1], log_we[b+1], log_wdata[b+1]} !== {16'h0100, 1'b1, 16'h1234})
            $display("FAIL sti_write: got addr=%h we=%b data=%h exp 0100 1 1234",
                     log_addr[b+1], log_we[b+1], log_wdata[b+1]);
        else n_pass++;
    endtask

    task automatic test_st_gnt_delay();
        int b = log_addr.size();
        int req_cycles = 0;
        gnt_delay = 3;
        issue(OP_ST, 16'h0500, 9'h010, 16'hABCD);
        for (int i = 0; i < 4; i++) begin
            if (i > 0) @(negedge clk);
            if (o_mem_req === 1'b1 && o_mem_we === 1'b1 && o_mem_addr === 16'h0510
                && o_mem_wdata === 16'hABCD && o_cmd_ready === 1'b0)
                req_cycles++;
            if (i == 0) begin
                i_cmd_valid = 1'b1;
                i_cmd_op    = OP_LD;
                i_cmd_base  = 16'h0600;
                i_cmd_off   = 9'd0;
            end
        end
        n_checks++;
        if (req_cycles !== 4) $display("FAIL st_stable: got %0d stable req cycles exp 4", req_cycles);
        else n_pass++;
        wait_rsp(4);
        i_cmd_valid = 1'b0;
        gnt_delay   = 0;
        n_checks++;
        if (c_lat !== 5) $display("FAIL st_latency: got %0d exp 5", c_lat);
        else n_pass++;
        n_checks++;
        if ({c_data, c_nzpe} !== {16'h0000, 4'b0000})
            $display("FAIL st_rsp: got data=%h nzpe=%b exp 0000 0000", c_data, c_nzpe);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if ({o_mem_req, o_cmd_ready, o_mem_addr} !== {1'b0, 1'b1, 16'h0510})
            $display("FAIL st_busy_ignored: got req=%b ready=%b addr=%h exp 0 1 0510",
                     o_mem_req, o_cmd_ready, o_mem_addr);
        else n_pass++;
        n_checks++;
        if (log_addr.size() - b !== 1 || log_wdata[b] !== 16'hABCD || log_we[b] !== 1'b1)
            $display("FAIL st_access: got count=%0d data=%h we=%b exp 1 abcd 1",
                     log_addr.size() - b, log_wdata[b], log_we[b]);
        else n_pass++;
    endtask

    task automatic test_wrap_pos();
        mem[16'h0001] = 16'h7FFF;
        issue(OP_LD, 16'hFFFF, 9'd2, 16'h0);
        n_checks++;
        if (o_mem_addr !== 16'h0001) $display("FAIL wrap_addr: got %h exp 0001", o_mem_addr);
        else n_pass++;
        wait_rsp(1);
        n_checks++;
        if ({c_data, c_nzpe} !== {16'h7FFF, 4'b0010})
            $display("FAIL wrap_rsp: got data=%h nzpe=%b exp 7fff 0010", c_data, c_nzpe);
        else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_timeout();
        rvalid_en = 1'b0;
        issue(OP_LD, 16'h0100, 9'd0, 16'h0);
        wait_rsp(1);
        n_checks++;
        if (c_lat !== 10) $display("FAIL timeout_latency: got %0d exp 10 (gnt+9)", c_lat);
        else n_pass++;
        n_checks++;
        if ({c_data, c_nzpe} !== {16'h0000, 4'b0001})
            $display("FAIL timeout_rsp: got data=%h nzpe=%b exp 0000 0001", c_data, c_nzpe);
        else n_pass++;
        @(negedge clk);
        rvalid_en = 1'b1;
        n_checks++;
        if ({o_rsp_valid, o_cmd_ready} !== 2'b01)
            $display("FAIL timeout_idle: got valid/ready=%b exp 01", {o_rsp_valid, o_cmd_ready});
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        int seen = 0;
        gnt_delay = 5;
        issue(OP_LDI, 16'h0010, 9'd5, 16'h0);
        @(negedge clk);
        n_checks++;
        if (o_mem_req !== 1'b1) $display("FAIL rstmid_pre: got req=%b exp 1", o_mem_req);
        else n_pass++;
        rst = 1'b1;
        #1;
        n_checks++;
        if ({o_mem_req, o_cmd_ready, o_rsp_valid} !== 3'b010)
            $display("FAIL rstmid_async: got req/ready/valid=%b exp 010", {o_mem_req, o_cmd_ready, o_rsp_valid});
        else n_pass++;
        @(negedge clk);
        rst        = 1'b0;
        gnt_delay  = 0;
        inject_req = inject_req + 1;
        repeat (6) begin
            @(negedge clk);
            if (o_rsp_valid !== 1'b0 || o_mem_req !== 1'b0) seen++;
        end
        n_checks++;
        if (seen !== 0 || o_cmd_ready !== 1'b1)
            $display("FAIL rstmid_late_rvalid: got %0d active cycles ready=%b exp 0 1", seen, o_cmd_ready);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        mem[16'h0300] = 16'h0042;
        mem[16'h0301] = 16'hFFFE;
        issue(OP_LD, 16'h0300, 9'd0, 16'h0);
        wait_rsp(1);
        n_checks++;
        if ({c_lat, c_data, c_nzpe} !== {32'd3, 16'h0042, 4'b0010})
            $display("FAIL b2b_first: got lat=%0d data=%h nzpe=%b exp 3 0042 0010", c_lat, c_data, c_nzpe);
        else n_pass++;
        issue(OP_LD, 16'h0300, 9'd1, 16'h0);
        wait_rsp(1);
        n_checks++;
        if ({c_lat, c_data, c_nzpe} !== {32'd3, 16'hFFFE, 4'b1000})
            $display("FAIL b2b_second: got lat=%0d data=%h nzpe=%b exp 3 fffe 1000", c_lat, c_data, c_nzpe);
        else n_pass++;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_ld_neg();
        test_ldi_zero();
        test_sti();
        test_st_gnt_delay();
        test_wrap_pos();
        test_timeout();
        test_reset_mid();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish by 100000 exp finish");
        $fatal(1, "watchdog expired");
    end

endmodule
